// File: rtl/seq_fsm_ctrl_if.sv
// ---------------------------------------------------------------------------
// seq_fsm_ctrl_if
// Bundles the control handshake, the table configuration port and the status
// outputs of seq_fsm_ctrl. clk and reset_n stay plain module ports.
//   master : drives start/abort/hold and cfg_*; observes state/status
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface seq_fsm_ctrl_if #(
   parameter int NUM_STATES = 4,
   parameter int DWELL_W    = 8
);
   localparam int SW = $clog2(NUM_STATES);

   logic                  start;
   logic                  abort;
   logic                  hold;
   logic                  cfg_we;
   logic [SW-1:0]         cfg_addr;
   logic [SW-1:0]         cfg_next;
   logic [DWELL_W-1:0]    cfg_dwell;
   logic [SW-1:0]         state;
   logic [NUM_STATES-1:0] state_onehot;
   logic                  busy;
   logic                  step;
   logic                  done;
   logic                  err;

   modport master (
      output start, abort, hold, cfg_we, cfg_addr, cfg_next, cfg_dwell,
      input  state, state_onehot, busy, step, done, err
   );

   modport slave (
      input  start, abort, hold, cfg_we, cfg_addr, cfg_next, cfg_dwell,
      output state, state_onehot, busy, step, done, err
   );
endinterface

// File: rtl/seq_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// seq_fsm_ctrl
// Table-driven sequencer: walks through up to NUM_STATES states using a
// run-time writable next-state/dwell table, started by `start`, frozen by
// `hold`, cancelled by `abort`, and finishing when the table points home (0).
//
// Ports
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset (also restores the table)
//   bus      : seq_fsm_ctrl_if.slave
//              start/abort/hold  - control inputs
//              cfg_we/addr/next/dwell - table write port
//              state, state_onehot, busy, step, done, err - status
//
// Optional feature: define SEQ_FSM_CTRL_WATCHDOG_EN to add a step-count
// watchdog that stops a sequence after MAX_STEPS transitions and sets err.
// ---------------------------------------------------------------------------
module seq_fsm_ctrl #(
   parameter int NUM_STATES = 4,
   parameter int DWELL_W    = 8,
   parameter int MAX_STEPS  = 64
) (
   input logic           clk,
   input logic           reset_n,
   seq_fsm_ctrl_if.slave bus
);
   localparam int SW = $clog2(NUM_STATES);

   // Elaboration-time range guard; nothing is built inside it.
   if (NUM_STATES < 2 || NUM_STATES > 16 || MAX_STEPS < 1) begin : g_param_range_violation
   end

   logic [SW-1:0]      next_r  [NUM_STATES];
   logic [DWELL_W-1:0] dwell_r [NUM_STATES];

   logic [SW-1:0]      state_r,   state_nxt_s;
   logic               busy_r,    busy_nxt_s;
   logic [DWELL_W-1:0] counter_r, counter_nxt_s;
   logic               step_r,    step_nxt_s;
   logic               done_r,    done_nxt_s;
   logic [SW-1:0]      look_next_s;
   logic [NUM_STATES-1:0] state_onehot_s;

`ifdef SEQ_FSM_CTRL_WATCHDOG_EN
   localparam int WDW = $clog2(MAX_STEPS + 1);
   logic [WDW-1:0]     wd_r, wd_nxt_s;
   logic               err_r, err_nxt_s;
`endif

   // Configuration table: reset to a linear 0->1->..->N-1->0 walk, zero dwell.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_STATES; i++) begin
            next_r[i]  <= SW'((i + 1) % NUM_STATES);
            dwell_r[i] <= {DWELL_W{1'b0}};
         end
      end else if (bus.cfg_we) begin
         next_r[bus.cfg_addr]  <= bus.cfg_next;
         dwell_r[bus.cfg_addr] <= bus.cfg_dwell;
      end
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= {SW{1'b0}};
         busy_r    <= 1'b0;
         counter_r <= {DWELL_W{1'b0}};
         step_r    <= 1'b0;
         done_r    <= 1'b0;
`ifdef SEQ_FSM_CTRL_WATCHDOG_EN
         wd_r      <= {WDW{1'b0}};
         err_r     <= 1'b0;
`endif
      end else begin
         state_r   <= state_nxt_s;
         busy_r    <= busy_nxt_s;
         counter_r <= counter_nxt_s;
         step_r    <= step_nxt_s;
         done_r    <= done_nxt_s;
`ifdef SEQ_FSM_CTRL_WATCHDOG_EN
         wd_r      <= wd_nxt_s;
         err_r     <= err_nxt_s;
`endif
      end
   end

   // Next-state logic: IDLE/RUN is busy_r; RUN priority abort > watchdog > hold > advance.
   always_comb begin
      state_nxt_s   = state_r;
      busy_nxt_s    = busy_r;
      counter_nxt_s = counter_r;
      step_nxt_s    = 1'b0;
      done_nxt_s    = 1'b0;
`ifdef SEQ_FSM_CTRL_WATCHDOG_EN
      wd_nxt_s      = wd_r;
      err_nxt_s     = err_r;
`endif
      // Table lookups see the pre-write contents during a same-cycle cfg write.
      look_next_s   = next_r[state_r];

      if (!busy_r) begin
         if (bus.start) begin
            busy_nxt_s    = 1'b1;
            counter_nxt_s = dwell_r[0];
`ifdef SEQ_FSM_CTRL_WATCHDOG_EN
            wd_nxt_s      = {WDW{1'b0}};
            err_nxt_s     = 1'b0;
`endif
         end else begin
            busy_nxt_s = 1'b0;
         end
      end else if (bus.abort) begin
         state_nxt_s = {SW{1'b0}};
         busy_nxt_s  = 1'b0;
`ifdef SEQ_FSM_CTRL_WATCHDOG_EN
      end else if (wd_r == WDW'(MAX_STEPS)) begin
         state_nxt_s = {SW{1'b0}};
         busy_nxt_s  = 1'b0;
         err_nxt_s   = 1'b1;
`endif
      end else if (bus.hold) begin
         busy_nxt_s = 1'b1;
      end else if (counter_r != {DWELL_W{1'b0}}) begin
         counter_nxt_s = counter_r - {{(DWELL_W-1){1'b0}}, 1'b1};
      end else begin
         step_nxt_s = 1'b1;
`ifdef SEQ_FSM_CTRL_WATCHDOG_EN
         wd_nxt_s   = wd_r + {{(WDW-1){1'b0}}, 1'b1};
`endif
         if (look_next_s != {SW{1'b0}}) begin
            state_nxt_s   = look_next_s;
            counter_nxt_s = dwell_r[look_next_s];
         end else begin
            state_nxt_s = {SW{1'b0}};
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b1;
         end
      end
   end

   // Output decode: one-hot of the registered state.
   always_comb begin
      state_onehot_s          = {NUM_STATES{1'b0}};
      state_onehot_s[state_r] = 1'b1;
   end

   assign bus.state        = state_r;
   assign bus.state_onehot = state_onehot_s;
   assign bus.busy         = busy_r;
   assign bus.step         = step_r;
   assign bus.done         = done_r;
`ifdef SEQ_FSM_CTRL_WATCHDOG_EN
   assign bus.err          = err_r;
`else
   assign bus.err          = 1'b0;
`endif
endmodule

// File: tb/tb_seq_fsm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_fsm_ctrl
// Directed scenarios followed by a random phase; every cycle the DUT outputs
// are compared with a reference model that tracks "cycles left in the current
// state" (dwell+1 occupancy) and a copy of the table.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_fsm_ctrl;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int MS = 8;

   logic clk = 1'b0;
   logic reset_n;
   int   errors = 0;
   int   checks = 0;

   seq_fsm_ctrl_if #(.NUM_STATES(N), .DWELL_W(DW)) bus ();

   seq_fsm_ctrl #(.NUM_STATES(N), .DWELL_W(DW), .MAX_STEPS(MS)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Reference model
   int m_next [N];
   int m_dwell[N];
   int m_state, m_left, m_wd;
   bit m_busy, m_step, m_done, m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_next[i]  = (i + 1) % N;
         m_dwell[i] = 0;
      end
      m_state = 0; m_left = 0; m_wd = 0;
      m_busy = 0; m_step = 0; m_done = 0; m_err = 0;
   endtask

   task automatic model_step();
      int nx;
      m_step = 0;
      m_done = 0;
      if (!m_busy) begin
         if (bus.start) begin
            m_busy = 1; m_left = m_dwell[0] + 1; m_err = 0; m_wd = 0;
         end
      end else if (bus.abort) begin
         m_busy = 0; m_state = 0;
`ifdef SEQ_FSM_CTRL_WATCHDOG_EN
      end else if (m_wd == MS) begin
         m_busy = 0; m_state = 0; m_err = 1;
`endif
      end else if (!bus.hold) begin
         m_left--;
         if (m_left == 0) begin
            nx = m_next[m_state];
            m_step = 1;
            m_wd++;
            if (nx != 0) begin
               m_state = nx; m_left = m_dwell[nx] + 1;
            end else begin
               m_state = 0; m_busy = 0; m_done = 1;
            end
         end
      end
      if (bus.cfg_we) begin
         m_next[bus.cfg_addr]  = bus.cfg_next;
         m_dwell[bus.cfg_addr] = bus.cfg_dwell;
      end
   endtask

   task automatic compare(input string pfx);
      chk({pfx, "_state"},  32'(bus.state),        32'(m_state));
      chk({pfx, "_onehot"}, 32'(bus.state_onehot), 32'(1) << m_state);
      chk({pfx, "_busy"},   32'(bus.busy),         32'(m_busy));
      chk({pfx, "_step"},   32'(bus.step),         32'(m_step));
      chk({pfx, "_done"},   32'(bus.done),         32'(m_done));
      chk({pfx, "_err"},    32'(bus.err),          32'(m_err));
   endtask

   // One clock: predict, clock, sample 1ns after the edge.
   task automatic tick(input string pfx);
      model_step();
      @(posedge clk);
      #1;
      compare(pfx);
   endtask

   task automatic set_ctl(input bit s, input bit a, input bit h);
      bus.start = s; bus.abort = a; bus.hold = h;
   endtask

   task automatic cfg_write(input int addr, input int nxt, input int dwl);
      bus.cfg_we = 1'b1;
      bus.cfg_addr = 2'(addr); bus.cfg_next = 2'(nxt); bus.cfg_dwell = 8'(dwl);
      tick("cfg");
      bus.cfg_we = 1'b0;
   endtask

   initial begin
      int seq_exp[4];
      int steps, done_at, c0, c1, c2, c3, dn;

      reset_n = 1'b0;
      set_ctl(1'b0, 1'b0, 1'b0);
      bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_next = 2'd0; bus.cfg_dwell = 8'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state",  32'(bus.state), 32'd0);
      chk("rst_onehot", 32'(bus.state_onehot), 32'd1);
      chk("rst_busy",   32'(bus.busy), 32'd0);
      chk("rst_step",   32'(bus.step), 32'd0);
      chk("rst_done",   32'(bus.done), 32'd0);
      chk("rst_err",    32'(bus.err), 32'd0);
      reset_n = 1'b1;
      tick("idle");

      // Default table walk: states 0,1,2,3 on t+1..t+4, done at t+5, 4 steps.
      seq_exp = '{0, 1, 2, 3};
      steps = 0; done_at = 0;
      for (int k = 1; k <= 6; k++) begin
         set_ctl(k == 1, 1'b0, 1'b0);
         tick("dflt");
         if (k <= 4) chk("dflt_seq", 32'(bus.state), 32'(seq_exp[k-1]));
         if (bus.step) steps++;
         if (bus.done) done_at = k;
      end
      chk("dflt_steps", 32'(steps), 32'd4);
      chk("dflt_done_at", 32'(done_at), 32'd5);

      // Programmed path 0 -> 2 (dwell 3) -> 3 -> home.
      cfg_write(0, 2, 0);
      cfg_write(2, 3, 3);
      cfg_write(3, 0, 0);
      c0 = 0; c2 = 0; c3 = 0; dn = 0;
      for (int k = 1; k <= 10; k++) begin
         set_ctl(k == 1, 1'b0, 1'b0);
         tick("prog");
         if (bus.busy && bus.state == 2'd0) c0++;
         if (bus.busy && bus.state == 2'd2) c2++;
         if (bus.busy && bus.state == 2'd3) c3++;
         if (bus.done) dn++;
      end
      chk("prog_s0_cycles", 32'(c0), 32'd1);
      chk("prog_s2_cycles", 32'(c2), 32'd4);
      chk("prog_s3_cycles", 32'(c3), 32'd1);
      chk("prog_done_cnt", 32'(dn), 32'd1);

      // Reset mid-sequence restores outputs and table immediately.
      set_ctl(1'b1, 1'b0, 1'b0);
      tick("mrst");
      set_ctl(1'b0, 1'b0, 1'b0);
      tick("mrst");
      reset_n = 1'b0;
      #2;
      model_reset();
      compare("mrst_async");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick("mrst_idle");

      // Hold for 3 cycles in state 1 stretches it to 4 cycles, done at t+8.
      c1 = 0; done_at = 0;
      for (int k = 1; k <= 10; k++) begin
         set_ctl(k == 1, 1'b0, (k >= 3 && k <= 5));
         tick("hold");
         if (bus.busy && bus.state == 2'd1) c1++;
         if (bus.done) done_at = k;
      end
      chk("hold_s1_cycles", 32'(c1), 32'd4);
      chk("hold_done_at", 32'(done_at), 32'd8);

      // Abort together with hold in state 2, then a normal run.
      dn = 0;
      for (int k = 1; k <= 10; k++) begin
         set_ctl(k == 1, k == 4, k == 4);
         tick("abort");
         if (k == 3) chk("abort_in_s2", 32'(bus.state), 32'd2);
         if (k == 4) begin
            chk("abort_busy", 32'(bus.busy), 32'd0);
            chk("abort_state", 32'(bus.state), 32'd0);
         end
         if (bus.done) dn++;
      end
      chk("abort_no_done", 32'(dn), 32'd0);
      for (int k = 1; k <= 6; k++) begin
         set_ctl(k == 1, 1'b0, 1'b0);
         tick("after_abort");
         if (bus.done) dn++;
      end
      chk("after_abort_done", 32'(dn), 32'd1);

      // Start while busy is ignored; rewriting current dwell applies next visit.
      set_ctl(1'b1, 1'b0, 1'b0);
      tick("rewr");
      set_ctl(1'b0, 1'b0, 1'b0);
      tick("rewr");
      set_ctl(1'b1, 1'b0, 1'b0);
      bus.cfg_we = 1'b1; bus.cfg_addr = 2'd1; bus.cfg_next = 2'd2; bus.cfg_dwell = 8'd2;
      tick("rewr");
      chk("rewr_moved_on", 32'(bus.state), 32'd2);
      bus.cfg_we = 1'b0;
      set_ctl(1'b0, 1'b0, 1'b0);
      repeat (4) tick("rewr");
      c1 = 0;
      for (int k = 1; k <= 9; k++) begin
         set_ctl(k == 1, 1'b0, 1'b0);
         tick("rewr2");
         if (bus.busy && bus.state == 2'd1) c1++;
      end
      chk("rewr_new_dwell", 32'(c1), 32'd3);

      // Self-loop on state 1: runs until abort (or watchdog when compiled in).
      cfg_write(1, 1, 0);
      set_ctl(1'b1, 1'b0, 1'b0);
      tick("loop");
      set_ctl(1'b0, 1'b0, 1'b0);
      repeat (30) tick("loop");
`ifdef SEQ_FSM_CTRL_WATCHDOG_EN
      chk("loop_err", 32'(bus.err), 32'd1);
      chk("loop_busy", 32'(bus.busy), 32'd0);
`else
      chk("loop_busy", 32'(bus.busy), 32'd1);
      chk("loop_state", 32'(bus.state), 32'd1);
`endif
      set_ctl(1'b0, 1'b1, 1'b0);
      tick("loop_abort");
      set_ctl(1'b0, 1'b0, 1'b0);
      cfg_write(1, 2, 0);
      set_ctl(1'b1, 1'b0, 1'b0);
      tick("loop_restart");
      chk("loop_restart_err", 32'(bus.err), 32'd0);
      set_ctl(1'b0, 1'b0, 1'b0);
      repeat (6) tick("loop_restart");

      // Random phase.
      for (int k = 0; k < 600; k++) begin
         set_ctl($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(3) == 0);
         bus.cfg_we    = ($urandom_range(7) == 0);
         bus.cfg_addr  = 2'($urandom_range(N - 1));
         bus.cfg_next  = 2'($urandom_range(N - 1));
         bus.cfg_dwell = 8'($urandom_range(3));
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
